// File: rtl/req_pending_tracker.sv
// Per-channel pending-transaction counters feeding a fixed-priority arbiter; push visible on req after 1 cycle, gnt retires in the same cycle.
// No backpressure: counters saturate at max, setting a sticky ovf; grants to empty channels or multi-hot grants set a sticky err_gnt.
module req_pending_tracker #(
  parameter int NCH = 4,
  parameter int CW  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    push,
  input  logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    req,
  output logic [NCH*CW-1:0] pend_cnt,
  output logic              busy,
  output logic [NCH-1:0]    ovf,
  output logic              err_gnt
);

  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] CONE = CW'(1);

  logic [CW-1:0]  cnt_q [NCH];
  logic [CW-1:0]  cnt_d [NCH];
  logic [NCH-1:0] nz;
  logic [NCH-1:0] inc;
  logic [NCH-1:0] dec;
  logic [NCH-1:0] ovf_d;
  logic           err_d;

  always_comb begin
    req      = '0;
    pend_cnt = '0;
    nz       = '0;
    inc      = '0;
    dec      = '0;
    ovf_d    = ovf;
    err_d    = err_gnt;
    if (!$onehot0(gnt)) err_d = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      nz[i]    = (cnt_q[i] != '0);
      inc[i]   = push[i];
      dec[i]   = gnt[i] && nz[i];
      if (gnt[i] && !nz[i]) err_d = 1'b1;
      // A simultaneous push and retire cancel out, even at saturation.
      if (inc[i] && !dec[i]) begin
        if (cnt_q[i] == CMAX) ovf_d[i] = 1'b1;
        else                  cnt_d[i] = cnt_q[i] + CONE;
      end else if (dec[i] && !inc[i]) begin
        cnt_d[i] = cnt_q[i] - CONE;
      end
      // Drop req as the last pending item is granted so the arbiter cannot re-grant it.
      req[i] = nz[i] && !((cnt_q[i] == CONE) && gnt[i]);
      pend_cnt[i*CW +: CW] = cnt_q[i];
    end
    busy = |nz;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      ovf     <= '0;
      err_gnt <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) cnt_q[i] <= cnt_d[i];
      ovf     <= ovf_d;
      err_gnt <= err_d;
    end
  end

endmodule

// File: tb/tb_req_pending_tracker.sv
// Bench for req_pending_tracker: directed scenarios then random traffic, checked against an integer reference model through a scoreboard queue.
module tb_req_pending_tracker;

  localparam int NCH = 4;
  localparam int CW  = 3;
  localparam int MAXV = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [NCH-1:0]    push;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    req;
  logic [NCH*CW-1:0] pend_cnt;
  logic              busy;
  logic [NCH-1:0]    ovf;
  logic              err_gnt;

  req_pending_tracker #(.NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .push(push), .gnt(gnt), .req(req),
    .pend_cnt(pend_cnt), .busy(busy), .ovf(ovf), .err_gnt(err_gnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NCH-1:0]    req;
    logic [NCH*CW-1:0] pc;
    logic              busy;
    logic [NCH-1:0]    ovf;
    logic              err;
  } exp_t;

  exp_t expq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  bit   stim_done = 1'b0;

  // Reference model state: pending counts as plain integers.
  int       mcnt [NCH];
  bit [NCH-1:0] movf;
  bit       merr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp_v, $time);
    end
  endtask

  // Drive one cycle on the falling edge, queue the outputs expected before the next rising edge, then advance the model.
  task automatic cyc(input logic r, input logic [NCH-1:0] p, input logic [NCH-1:0] g);
    exp_t e;
    int   ng;
    @(negedge clk);
    rst = r; push = p; gnt = g;
    #1;
    e = '0;
    for (int i = 0; i < NCH; i++) begin
      e.req[i] = (mcnt[i] > 0) && !(mcnt[i] == 1 && g[i]);
      e.pc[i*CW +: CW] = CW'(mcnt[i]);
      if (mcnt[i] > 0) e.busy = 1'b1;
    end
    e.ovf = movf;
    e.err = merr;
    expq.push_back(e);
    if (r) begin
      for (int i = 0; i < NCH; i++) mcnt[i] = 0;
      movf = '0;
      merr = 1'b0;
    end else begin
      ng = 0;
      for (int i = 0; i < NCH; i++) begin
        bit did_dec;
        if (g[i]) ng++;
        did_dec = g[i] && mcnt[i] > 0;
        if (g[i] && mcnt[i] == 0) merr = 1'b1;
        if (p[i] && !did_dec) begin
          if (mcnt[i] == MAXV) movf[i] = 1'b1;
          else mcnt[i] = mcnt[i] + 1;
        end else if (did_dec && !p[i]) begin
          mcnt[i] = mcnt[i] - 1;
        end
      end
      if (ng > 1) merr = 1'b1;
    end
  endtask

  // Monitor: every cycle the DUT presents a settled output set; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("req",      32'(req),      32'(e.req));
        chk("pend_cnt", 32'(pend_cnt), 32'(e.pc));
        chk("busy",     32'(busy),     32'(e.busy));
        chk("ovf",      32'(ovf),      32'(e.ovf));
        chk("err_gnt",  32'(err_gnt),  32'(e.err));
      end
    end
  end

  initial begin
    logic [NCH-1:0] rp, rg;
    int sel, wait_cyc;
    rst = 1'b1; push = '0; gnt = '0;
    for (int i = 0; i < NCH; i++) mcnt[i] = 0;
    movf = '0; merr = 1'b0;
    repeat (2) @(posedge clk);

    cyc(1, 4'b0000, 4'b0000);
    // Single push
    cyc(0, 4'b0100, 4'b0000);
    cyc(0, 4'b0000, 4'b0000);
    // Grant retire with lookahead
    cyc(0, 4'b0000, 4'b0100);
    cyc(0, 4'b0000, 4'b0000);
    // Multi-pending, push+gnt together
    repeat (3) cyc(0, 4'b0101, 4'b0000);
    cyc(0, 4'b0001, 4'b0001);
    cyc(0, 4'b0000, 4'b0000);
    cyc(1, 4'b0000, 4'b0000);
    // Overflow then push+gnt at max
    repeat (8) cyc(0, 4'b1000, 4'b0000);
    cyc(0, 4'b0000, 4'b0000);
    cyc(0, 4'b1000, 4'b1000);
    cyc(0, 4'b0000, 4'b0000);
    cyc(1, 4'b0000, 4'b0000);
    // Spurious grant
    cyc(0, 4'b0000, 4'b0010);
    cyc(0, 4'b0000, 4'b0000);
    cyc(1, 4'b0000, 4'b0000);
    // Illegal multi-hot grant, both channels still retire
    cyc(0, 4'b1010, 4'b0000);
    cyc(0, 4'b0000, 4'b1010);
    cyc(0, 4'b0000, 4'b0000);
    cyc(1, 4'b0000, 4'b0000);
    // Reset mid-operation with concurrent push
    repeat (8) cyc(0, 4'b1000, 4'b0000);
    repeat (2) cyc(0, 4'b0011, 4'b0000);
    repeat (3) cyc(0, 4'b0010, 4'b0000);
    cyc(1, 4'b1111, 4'b0000);
    cyc(0, 4'b0000, 4'b0000);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rp = NCH'($urandom) & NCH'($urandom);
      sel = $urandom_range(0, 9);
      rg = '0;
      if (sel < 6) begin
        int ch;
        ch = $urandom_range(0, NCH-1);
        if (mcnt[ch] > 0 || sel == 0) rg[ch] = 1'b1;
      end else if (sel == 9) begin
        rg = NCH'($urandom);
      end
      cyc(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, rp, rg);
    end
    cyc(0, 4'b0000, 4'b0000);
    stim_done = 1'b1;

    wait_cyc = 0;
    while (expq.size() > 0 && wait_cyc < 20) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (expq.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
